// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants and state encoding for the cache-line to burst-memory adaptor.
package cacheline_adaptor_pkg;

    localparam int LINE_W      = 256;
    localparam int BURST_W     = 64;
    localparam int BEATS       = LINE_W / BURST_W;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns whole-line read/write requests from the cache into fixed 4-beat bursts on
// the memory side and answers the cache with a one-cycle resp pulse.
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);
    import cacheline_adaptor_pkg::*;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);

    adaptor_state_t    state;
    logic [1:0]        cnt;
    logic [LINE_W-1:0] wbuf;
    logic              last_beat;

    assign last_beat = resp_i && (cnt == 2'(BEATS - 1));

    // The write buffer shifts down one beat per accepted strobe, so the next beat
    // to present is always sitting just above the one currently on burst_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wbuf      <= '0;
            line_o    <= '0;
            burst_o   <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_i) begin
                        address_o <= address_i & ALIGN_MASK;
                        cnt       <= '0;
                        read_o    <= 1'b1;
                        state     <= RD_BURST;
                    end else if (write_i) begin
                        address_o <= address_i & ALIGN_MASK;
                        wbuf      <= line_i;
                        burst_o   <= line_i[BURST_W-1:0];
                        cnt       <= '0;
                        write_o   <= 1'b1;
                        state     <= WR_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_o[cnt*BURST_W +: BURST_W] <= burst_i;
                        cnt <= cnt + 2'd1;
                        if (last_beat) begin
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= RD_DONE;
                        end
                    end
                end
                RD_DONE: state <= IDLE;
                WR_BURST: begin
                    if (resp_i) begin
                        wbuf    <= wbuf >> BURST_W;
                        burst_o <= wbuf[2*BURST_W-1 -: BURST_W];
                        cnt     <= cnt + 2'd1;
                        if (last_beat) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            burst_o <= '0;
                            state   <= WR_DONE;
                        end
                    end
                end
                WR_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
